fifo_sync_ctrl: RTL

- Single-clock pointer/flag controller that sequences the `fifomem` dual-port RAM when its `wclk` and `rclk` are tied to one clock.
- Accepts producer `push` and consumer `pop` requests and generates the RAM write/read enables and addresses.
- Maintains full/empty, occupancy and almost-full/almost-empty flags, plus an `rvalid` strobe aligned to the RAM's registered `rdata`.
- Used wherever a same-clock FIFO is needed.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ptr.sv | 40 ++++
 rtl/fifo_sync_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the same-clock FIFO slice.
//   DATASIZE_DEF / ADDRSIZE_DEF : default RAM word width and address bits
//   depth()                     : number of RAM words for a given address width
//   occ_t                       : occupancy type (0..DEPTH) at the default size
package fifo_pkg;

    localparam int unsigned DATASIZE_DEF = 8;
    localparam int unsigned ADDRSIZE_DEF = 4;

    typedef logic [ADDRSIZE_DEF:0] occ_t;

    function automatic int unsigned depth(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: WIDTH-bit binary pointer that increments when enabled and
// returns to zero on a synchronous clear. Used for both the write and read
// pointers. The MSB acts as a wrap bit, so the pointer wraps modulo 2^WIDTH.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the pointer by one
//   clr        : synchronous clear (wins over en)
//   ptr        : registered pointer value
module fifo_ptr #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (en) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: single-clock pointer/flag controller for a fifomem
// dual-port RAM whose write and read clocks are tied together.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, pop         : producer / consumer requests
//   flush             : synchronous soft clear of pointers, count and flags
//   clr_err           : synchronous clear of the sticky error flags
//   wclken, waddr     : RAM write enable / address
//   rclken, raddr     : RAM read enable / address
//   wfull, rempty     : registered full / empty
//   almost_full/empty : registered threshold flags
//   count             : registered occupancy, 0..DEPTH
//   rvalid            : RAM rdata is valid this cycle
//   ovf_err, udf_err  : sticky push-while-full / pop-while-empty
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE   = DATASIZE_DEF,
    parameter int unsigned ADDRSIZE   = ADDRSIZE_DEF,
    parameter int unsigned AFULL_LVL  = 12,
    parameter int unsigned AEMPTY_LVL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic                clr_err,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rclken,
    output logic                wfull,
    output logic                rempty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                rvalid,
    output logic                ovf_err,
    output logic                udf_err
);

    localparam int unsigned       DEPTH    = depth(ADDRSIZE);
    localparam logic [ADDRSIZE:0] DEPTH_C  = DEPTH[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] AFULL_C  = AFULL_LVL[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] AEMPTY_C = AEMPTY_LVL[ADDRSIZE:0];

    // DATASIZE only sizes the RAM; it is checked here so a bad value is
    // caught at elaboration rather than in the wrapper.
    if (DATASIZE < 1) begin : g_bad_datasize
        $error("fifo_sync_ctrl: DATASIZE must be at least 1");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("fifo_sync_ctrl: AFULL_LVL must be in 1..DEPTH");
    end
    if (AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync_ctrl: AEMPTY_LVL must be in 0..DEPTH-1");
    end

    logic                wr_ok;
    logic                rd_ok;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   rptr;

    logic [ADDRSIZE:0]   count_q, count_d;
    logic                wfull_q, wfull_d;
    logic                rempty_q, rempty_d;
    logic                afull_q, afull_d;
    logic                aempty_q, aempty_d;
    logic                rvalid_q, rvalid_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    // Accept decisions use only registered flags, so push and pop in the
    // same cycle are independent. flush suppresses both RAM accesses.
    always_comb begin
        wr_ok = push & ~wfull_q  & ~flush;
        rd_ok = pop  & ~rempty_q & ~flush;
    end

    fifo_ptr #(.WIDTH(ADDRSIZE + 1)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_ok),
        .clr   (flush),
        .ptr   (wptr)
    );

    fifo_ptr #(.WIDTH(ADDRSIZE + 1)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_ok),
        .clr   (flush),
        .ptr   (rptr)
    );

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end

        // Flags follow the next occupancy, so a flush lands on reset values.
        wfull_d  = (count_d == DEPTH_C);
        rempty_d = (count_d == '0);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);

        // RAM rdata is registered, so it becomes valid one edge after rd_ok.
        rvalid_d = rd_ok;

        // A new error in the same cycle as clr_err keeps the flag set.
        ovf_d = (clr_err ? 1'b0 : ovf_q) | (push & wfull_q  & ~flush);
        udf_d = (clr_err ? 1'b0 : udf_q) | (pop  & rempty_q & ~flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign wclken       = wr_ok;
    assign rclken       = rd_ok;
    assign waddr        = wptr[ADDRSIZE-1:0];
    assign raddr        = rptr[ADDRSIZE-1:0];
    assign wfull        = wfull_q;
    assign rempty       = rempty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign rvalid       = rvalid_q;
    assign ovf_err      = ovf_q;
    assign udf_err      = udf_q;

endmodule
